// File: rtl/load_memory_pkg.sv
// Access-size encoding and lane/alignment helpers shared by the load and store paths.
package load_memory_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  function automatic logic [3:0] lane_sel(input mem_size_e size, input logic [1:0] offset);
    case (size)
      MEM_BYTE: lane_sel = 4'b0001 << offset;
      MEM_HALF: lane_sel = 4'b0011 << offset;
      MEM_WORD: lane_sel = 4'b1111;
      default:  lane_sel = 4'b0000;
    endcase
  endfunction

  // Reserved size is treated as misaligned so both paths reject it the same way.
  function automatic logic misaligned(input mem_size_e size, input logic [1:0] offset);
    case (size)
      MEM_BYTE: misaligned = 1'b0;
      MEM_HALF: misaligned = (offset == 2'd3);
      MEM_WORD: misaligned = (offset != 2'd0);
      default:  misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_memory_decoder.sv
// Extracts the addressed byte/halfword/word from a bus word and extends it to 32 bits.
module load_memory_decoder
  import load_memory_pkg::*;
(
  input  mem_size_e   size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (size)
      MEM_BYTE: data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      MEM_HALF: data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      MEM_WORD: data = rdata;
      default:  data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_memory_unit.sv
// Load unit: one word-aligned bus read per request, extended result to writeback.
// Optional bus timeout enabled by defining LOAD_UNIT_TIMEOUT_EN.
module load_memory_unit
  import load_memory_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_type,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_sel,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_exception,
  output logic              rsp_fault
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e      state;
  mem_size_e   req_size;
  mem_size_e   size_q;
  logic        unsigned_q;
  logic [1:0]  offset_q;
  logic [1:0]  req_offset;
  logic [31:0] load_data;

  assign req_size   = mem_size_e'(req_type);
  assign req_offset = req_addr[1:0];

  load_memory_decoder u_decoder (
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .offset      (offset_q),
    .rdata       (mem_rdata),
    .data        (load_data)
  );

`ifdef LOAD_UNIT_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_count;
  logic       fault_q;
  assign rsp_fault = fault_q;
`else
  assign rsp_fault = 1'b0;
`endif

  // Illegal requests skip the bus entirely and report straight from IDLE to RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_sel       <= 4'b0000;
      rsp_valid     <= 1'b0;
      rsp_data      <= 32'd0;
      rsp_exception <= 1'b0;
      size_q        <= MEM_BYTE;
      unsigned_q    <= 1'b0;
      offset_q      <= 2'd0;
`ifdef LOAD_UNIT_TIMEOUT_EN
      wait_count    <= 8'd0;
      fault_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            offset_q   <= req_offset;
`ifdef LOAD_UNIT_TIMEOUT_EN
            wait_count <= 8'd0;
            fault_q    <= 1'b0;
`endif
            if (misaligned(req_size, req_offset)) begin
              state         <= RESP;
              rsp_valid     <= 1'b1;
              rsp_exception <= 1'b1;
              rsp_data      <= 32'd0;
            end else begin
              state         <= REQ;
              mem_req       <= 1'b1;
              mem_addr      <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_sel       <= lane_sel(req_size, req_offset);
              rsp_exception <= 1'b0;
            end
          end
        end
        // An ack on the limit cycle takes priority over the timeout.
        REQ: begin
          if (mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= load_data;
          end
`ifdef LOAD_UNIT_TIMEOUT_EN
          else if (wait_count == TIMEOUT_LIMIT) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= 32'd0;
            fault_q   <= 1'b1;
          end else begin
            wait_count <= wait_count + 8'd1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_memory_unit.sv
// Directed bench for load_memory_unit with a transaction-level expected-output model.
module tb_load_memory_unit;

`ifdef LOAD_UNIT_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_type = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_exception;
  logic        rsp_fault;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic        exp_req_ready = 1'b1;
  logic        exp_mem_req = 1'b0;
  logic [31:0] exp_mem_addr = 32'd0;
  logic [3:0]  exp_mem_sel = 4'd0;
  logic        exp_rsp_valid = 1'b0;
  logic [31:0] exp_rsp_data = 32'd0;
  logic        exp_exc = 1'b0;
  logic        exp_fault = 1'b0;

  load_memory_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_exception(rsp_exception), .rsp_fault(rsp_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Access width in bytes: 1, 2, 4; 0 for the reserved code.
  function automatic int model_bytes(input logic [1:0] t);
    case (t)
      2'b00: return 1;
      2'b01: return 2;
      2'b10: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_legal(input logic [1:0] t, input logic [31:0] addr);
    int n = model_bytes(t);
    return (n != 0) && (int'(addr[1:0]) + n <= 4);
  endfunction

  function automatic logic [3:0] model_sel(input logic [1:0] t, input logic [31:0] addr);
    logic [3:0] s = 4'd0;
    int off = int'(addr[1:0]);
    int n = model_bytes(t);
    for (int b = 0; b < 4; b++) s[b] = (b >= off) && (b < off + n);
    return s;
  endfunction

  function automatic logic [31:0] model_data(input logic [1:0] t, input logic u,
                                             input logic [31:0] addr, input logic [31:0] rdata);
    int n = model_bytes(t);
    logic [31:0] mask;
    logic [31:0] val;
    mask = (n == 4) ? 32'hffff_ffff : ((32'd1 << (8 * n)) - 32'd1);
    val  = (rdata >> (8 * int'(addr[1:0]))) & mask;
    if (!u && n < 4 && val[8*n-1]) val = val | ~mask;
    return val;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("req_ready", {31'd0, req_ready}, {31'd0, exp_req_ready});
      check("mem_req", {31'd0, mem_req}, {31'd0, exp_mem_req});
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rsp_valid});
      if (exp_mem_req) begin
        check("mem_addr", mem_addr, exp_mem_addr);
        check("mem_sel", {28'd0, mem_sel}, {28'd0, exp_mem_sel});
      end
      if (exp_rsp_valid) begin
        check("rsp_data", rsp_data, exp_rsp_data);
        check("rsp_exception", {31'd0, rsp_exception}, {31'd0, exp_exc});
        check("rsp_fault", {31'd0, rsp_fault}, {31'd0, exp_fault});
      end
    end
  end

  task automatic finish_response(input int rdy_dly);
    repeat (rdy_dly) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_rsp_valid = 1'b0;
    exp_req_ready = 1'b1;
    exp_fault = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] t, input logic u, input logic [31:0] addr,
                               input logic [31:0] rdata, input int ack_dly, input int rdy_dly,
                               input logic [31:0] lit_data, input logic [3:0] lit_sel);
    bit legal = model_legal(t, addr);
    req_valid = 1'b1; req_type = t; req_unsigned = u; req_addr = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_req_ready = 1'b0;
    if (legal) begin
      exp_mem_req  = 1'b1;
      exp_mem_addr = addr & 32'hffff_fffc;
      exp_mem_sel  = model_sel(t, addr);
      check("lit_sel", {28'd0, mem_sel}, {28'd0, lit_sel});
      repeat (ack_dly) begin
        @(posedge clk); #1;
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
      exp_mem_req   = 1'b0;
      exp_rsp_valid = 1'b1;
      exp_rsp_data  = model_data(t, u, addr, rdata);
      exp_exc       = 1'b0;
    end else begin
      exp_rsp_valid = 1'b1;
      exp_rsp_data  = 32'd0;
      exp_exc       = 1'b1;
      check("lit_no_req", {31'd0, mem_req}, 32'd0);
    end
    check("lit_data", rsp_data, lit_data);
    finish_response(rdy_dly);
  endtask

  task automatic checkOutput_reset();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_sel", {28'd0, mem_sel}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_exception", {31'd0, rsp_exception}, 32'd0);
    check("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput_reset();
    reset = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    applyStimulus(2'b00, 1'b0, 32'h0000_1003, 32'h80aa_bbcc, 0, 0, 32'hffff_ff80, 4'b1000);
    applyStimulus(2'b01, 1'b1, 32'h0000_2001, 32'h12fe_dc34, 0, 0, 32'h0000_fedc, 4'b0110);
    applyStimulus(2'b01, 1'b0, 32'h0000_2001, 32'h12fe_dc34, 0, 1, 32'hffff_fedc, 4'b0110);
    applyStimulus(2'b10, 1'b0, 32'h0000_3002, 32'h0, 0, 0, 32'h0, 4'b0000);
    applyStimulus(2'b11, 1'b0, 32'h0000_4000, 32'h0, 0, 0, 32'h0, 4'b0000);
    applyStimulus(2'b01, 1'b1, 32'h0000_4003, 32'h0, 0, 0, 32'h0, 4'b0000);
    applyStimulus(2'b10, 1'b0, 32'h0000_5000, 32'hdead_beef, 5, 3, 32'hdead_beef, 4'b1111);
    applyStimulus(2'b00, 1'b1, 32'h0000_6002, 32'h00a5_0000, 1, 0, 32'h0000_00a5, 4'b0100);
    applyStimulus(2'b01, 1'b0, 32'h0000_7002, 32'h8001_0000, 2, 2, 32'hffff_8001, 4'b1100);
    applyStimulus(2'b00, 1'b0, 32'h0000_7000, 32'h1234_567f, 0, 0, 32'h0000_007f, 4'b0001);

    // Reset while the bus read is outstanding, then a stray ack afterwards.
    req_valid = 1'b1; req_type = 2'b10; req_unsigned = 1'b0; req_addr = 32'h0000_9000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_req_ready = 1'b0; exp_mem_req = 1'b1;
    exp_mem_addr = 32'h0000_9000; exp_mem_sel = model_sel(2'b10, 32'h0000_9000);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_mem_req = 1'b0; exp_req_ready = 1'b1; exp_rsp_valid = 1'b0;
    #1;
    check("async_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hcafe_f00d;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    applyStimulus(2'b01, 1'b1, 32'h0000_a000, 32'h5555_abcd, 0, 0, 32'h0000_abcd, 4'b0011);

`ifdef LOAD_UNIT_TIMEOUT_EN
    req_valid = 1'b1; req_type = 2'b10; req_unsigned = 1'b0; req_addr = 32'h0000_8000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_req_ready = 1'b0; exp_mem_req = 1'b1;
    exp_mem_addr = 32'h0000_8000; exp_mem_sel = 4'b1111;
    repeat (TB_TIMEOUT - 1) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    exp_mem_req = 1'b0; exp_rsp_valid = 1'b1; exp_rsp_data = 32'd0;
    exp_exc = 1'b0; exp_fault = 1'b1;
    check("lit_fault", {31'd0, rsp_fault}, 32'd1);
    finish_response(1);
    applyStimulus(2'b10, 1'b0, 32'h0000_8000, 32'h1122_3344, TB_TIMEOUT - 1, 0, 32'h1122_3344, 4'b1111);
`endif

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_memory_unit.md
Name: load_memory_unit

Overview:
- Load-side counterpart of the store path: accepts a load request from the execute stage and issues a single word-aligned read on the data memory bus.
- Waits for the bus response, then extracts the addressed byte, halfword or word from the returned word and sign- or zero-extends it to 32 bits.
- Flags misaligned and unsupported accesses without touching the bus.
- Sits between the execute stage and the data memory port; the writeback stage consumes its result.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYCLES, 255, bus wait limit; used only with LOAD_UNIT_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  load request strobe.
- req_ready  output  1  unit can accept a request (state IDLE).
- req_type  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  1 zero-extends, 0 sign-extends.
- req_addr  input  ADDR_W  byte address.
- mem_req  output  1  bus read request.
- mem_addr  output  ADDR_W  word-aligned address; low 2 bits are 0.
- mem_sel  output  4  byte lanes read.
- mem_ack  input  1  read data valid.
- mem_rdata  input  32  read word.
- rsp_valid  output  1  result or exception valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  32  extended load data.
- rsp_exception  output  1  misaligned or reserved access.
- rsp_fault  output  1  bus timeout; tied 0 when LOAD_UNIT_TIMEOUT_EN is undefined.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset: state IDLE. req_ready=1; mem_req=0, mem_addr=0, mem_sel=0; rsp_valid=0, rsp_data=0, rsp_exception=0, rsp_fault=0.
- Request handshake: a request is accepted on a rising edge with req_valid && req_ready. At acceptance the unit registers type, unsigned flag and the 2-bit address offset.
- Alignment check, using offset = req_addr[1:0]:
  - byte: any offset is legal.
  - half: offset 0–2 is legal; offset 3 is illegal.
  - word: only offset 0 is legal.
  - type 11: always illegal.
- States:
  - IDLE, legal request accepted → REQ. mem_req=1, mem_addr={req_addr[ADDR_W-1:2],2'b00}. mem_sel: byte = 0001<<offset, half = 0011<<offset, word = 1111.
  - IDLE, illegal request accepted → RESP with rsp_exception=1 and rsp_data=0. No bus activity.
  - REQ: mem_req, mem_addr and mem_sel held stable until mem_ack.
    - mem_ack sampled high → RESP. mem_req drops on the same edge. rsp_data = the lane(s) of mem_rdata selected by offset, shifted to bit 0, then extended.
    - Half at offset 1 uses mem_rdata[23:8].
  - RESP: rsp_valid=1 and outputs held stable. rsp_valid && rsp_ready → IDLE.
- Latency:
  - Legal load: minimum 2 cycles from acceptance to rsp_valid (1 cycle in REQ with mem_ack in that cycle, then RESP).
  - Exception: rsp_valid 1 cycle after acceptance.
- req_ready=0 in every state except IDLE. A new request cannot overlap; it is accepted only once the unit returns to IDLE.
- mem_ack outside REQ is ignored.
- Reset mid-transaction drops mem_req immediately (asynchronous) and discards any pending result.

Optional Feature:
- Macro: LOAD_UNIT_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to REQ and increments each cycle in REQ without mem_ack. When the count reaches TIMEOUT_CYCLES the unit goes to RESP with rsp_fault=1, rsp_data=0, mem_req=0. A mem_ack on the same cycle as the limit wins; no fault is raised.
- Undefined: no counter; REQ waits indefinitely; rsp_fault is constant 0.

Decomposition:
- Shared package (with the store path):
  - access-size enum: MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10.
  - function computing the byte-lane select from (size, offset).
  - misalignment predicate, reused by the store encoder.
- One combinational sub-module, load_memory_decoder: (type, unsigned, offset, rdata) → extended data. It is the inverse of the store encoder. The FSM stays in load_memory_unit.

Test Plan:
- LB signed: addr 0x1003, mem_rdata 0x80aabbcc, ack next cycle → mem_addr 0x1000, mem_sel 1000, rsp_data 0xffffff80, rsp_exception 0.
- LHU: addr 0x2001, mem_rdata 0x12fedc34 → mem_sel 0110, rsp_data 0x0000fedc. LH at the same address gives 0xfffffedc.
- LW misaligned: addr 0x3002 → mem_req never asserts; rsp_valid on the next cycle with rsp_exception 1. Reserved type 11 behaves the same.
- Backpressure: ack delayed 5 cycles, then rsp_ready held low 3 cycles:
  - mem_req, mem_addr, mem_sel stable throughout.
  - rsp_data stable while rsp_valid.
  - req_ready 0 until the handshake completes.
- Reset asserted while in REQ → mem_req 0 asynchronously. A mem_ack after reset is ignored and rsp_valid stays 0.
- With LOAD_UNIT_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → rsp_fault 1 after 4 cycles in REQ. A second run with ack on cycle 4 returns data with no fault.
